// File: rtl/instruction_fetch_if.sv
// Bus bundle for the instruction_fetch stage.
// Groups the loader handshake, the instruction-memory port, the pipeline
// control inputs and the IF/ID register outputs.
//   master : the fetch stage itself (drives load_ready, imem_*, ifid_*,
//            fetch_fault, state_o)
//   slave  : the surroundings (loader, memory, hazard/branch logic)
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
);
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  load_done;
  logic                  imem_we;
  logic [DATA_WIDTH-1:0] imem_data;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_q;
  logic                  stall;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  ifid_valid;
  logic [31:0]           ifid_instr;
  logic [ADDR_WIDTH-1:0] ifid_pc;
  logic [ADDR_WIDTH-1:0] ifid_pc_plus4;
  logic                  fetch_fault;
  logic [1:0]            state_o;

  modport master (
    input  load_valid, load_data, load_done, imem_q,
           stall, branch_taken, branch_target,
    output load_ready, imem_we, imem_data, imem_addr,
           ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4,
           fetch_fault, state_o
  );

  modport slave (
    output load_valid, load_data, load_done, imem_q,
           stall, branch_taken, branch_target,
    input  load_ready, imem_we, imem_data, imem_addr,
           ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4,
           fetch_fault, state_o
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: front-end stage owning the byte-addressed instruction
// memory port.
//   LOAD : streams loader bytes into memory (valid/ready), write pointer
//          drives imem_addr, imem_we is combinational.
//   RUN  : PC drives imem_addr, the big-endian word on imem_q is captured
//          into IF/ID each edge; handles stall and branch redirect.
//   HALT : entered on an illegal fetch address; left only through rst.
// Ports: clk, rst (async, active high), bus (instruction_fetch_if.master).
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PROG_BYTES = 91
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [31:0]           NOP_INSTR    = 32'h0000_0013;
  localparam logic [ADDR_WIDTH-1:0] PROG_BYTES_A = ADDR_WIDTH'(PROG_BYTES);
  localparam logic [ADDR_WIDTH:0]   PROG_BYTES_W = (ADDR_WIDTH+1)'(PROG_BYTES);

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] load_ptr_r;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic                  fetch_fault_r;
  logic                  ifid_valid_r;
  logic [31:0]           ifid_instr_r;
  logic [ADDR_WIDTH-1:0] ifid_pc_r;
  logic [ADDR_WIDTH-1:0] ifid_pc_plus4_r;

  logic                  load_ready_s;
  logic                  accept_s;
  logic                  load_full_s;
  logic                  pc_legal_s;
  logic [ADDR_WIDTH-1:0] pc_plus4_s;

  // Loader handshake, load-complete detection and PC legality.
  always_comb begin
    load_ready_s = 1'b0;
    if (state_r == ST_LOAD) begin
      load_ready_s = (load_ptr_r < PROG_BYTES_A);
    end else begin
      load_ready_s = 1'b0;
    end
    accept_s = load_ready_s & bus.load_valid;
    // Memory is full either when this byte fills the last slot or when the
    // pointer already sits at the end (covers a zero-sized memory).
    if (accept_s) begin
      load_full_s = ((load_ptr_r + ADDR_WIDTH'(1)) == PROG_BYTES_A);
    end else begin
      load_full_s = (load_ptr_r >= PROG_BYTES_A);
    end
    pc_plus4_s = pc_r + ADDR_WIDTH'(4);
    // Compare one bit wider so that the last word check cannot overflow.
    pc_legal_s = (pc_r[1:0] == 2'b00) &&
                 (({1'b0, pc_r} + (ADDR_WIDTH+1)'(4)) <= PROG_BYTES_W);
  end

  // Memory port muxing: write pointer while loading, PC otherwise.
  always_comb begin
    bus.load_ready = load_ready_s;
    bus.imem_we    = accept_s;
    if (state_r == ST_LOAD) begin
      bus.imem_addr = load_ptr_r;
      bus.imem_data = bus.load_data;
    end else begin
      bus.imem_addr = pc_r;
      bus.imem_data = {DATA_WIDTH{1'b0}};
    end
  end

  // Stage state machine: loader pointer, PC, fault flag and IF/ID register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_LOAD;
      load_ptr_r      <= '0;
      pc_r            <= RESET_PC;
      fetch_fault_r   <= 1'b0;
      ifid_valid_r    <= 1'b0;
      ifid_instr_r    <= NOP_INSTR;
      ifid_pc_r       <= '0;
      ifid_pc_plus4_r <= '0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (accept_s) begin
            load_ptr_r <= load_ptr_r + ADDR_WIDTH'(1);
          end
          if (bus.load_done || load_full_s) begin
            state_r <= ST_RUN;
            pc_r    <= RESET_PC;
          end
        end
        ST_RUN: begin
          if (bus.branch_taken) begin
            // Redirect wins over stall; the slot becomes a bubble.
            pc_r         <= bus.branch_target;
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= NOP_INSTR;
          end else if (!pc_legal_s) begin
            state_r       <= ST_HALT;
            fetch_fault_r <= 1'b1;
            ifid_valid_r  <= 1'b0;
          end else if (bus.stall) begin
            pc_r <= pc_r;
          end else begin
            ifid_instr_r    <= bus.imem_q;
            ifid_pc_r       <= pc_r;
            ifid_pc_plus4_r <= pc_plus4_s;
            ifid_valid_r    <= 1'b1;
            pc_r            <= pc_plus4_s;
          end
        end
        ST_HALT: begin
          ifid_valid_r  <= 1'b0;
          fetch_fault_r <= 1'b1;
        end
        default: begin
          // Corrupted state encoding is treated as a fault.
          state_r       <= ST_HALT;
          ifid_valid_r  <= 1'b0;
          fetch_fault_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ifid_valid    = ifid_valid_r;
  assign bus.ifid_instr    = ifid_instr_r;
  assign bus.ifid_pc       = ifid_pc_r;
  assign bus.ifid_pc_plus4 = ifid_pc_plus4_r;
  assign bus.fetch_fault   = fetch_fault_r;
  assign bus.state_o       = state_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a byte memory model that
// writes on the falling edge and reads a big-endian word combinationally.
module tb_instruction_fetch;

  logic clk;
  logic rst;

  instruction_fetch_if ifc ();

  instruction_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model, 91 bytes.
  logic [7:0]  mem [0:90];
  logic [31:0] q_s;
  int          idx_s;

  always @(negedge clk) begin
    if (ifc.imem_we && ifc.imem_addr < 32'd91) begin
      mem[ifc.imem_addr[6:0]] <= ifc.imem_data;
    end
  end

  always_comb begin
    q_s   = 32'h0;
    idx_s = 0;
    for (int k = 0; k < 4; k++) begin
      idx_s = int'(ifc.imem_addr) + k;
      if (ifc.imem_addr < 32'd88 || (idx_s >= 0 && idx_s < 91)) begin
        q_s[31-8*k -: 8] = mem[idx_s[6:0]];
      end
    end
  end
  assign ifc.imem_q = q_s;

  int n_checks;
  int n_pass;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"}, 32'(ifc.state_o), 32'd0);
    check_eq({tag, "_ready"}, 32'(ifc.load_ready), 32'd1);
    check_eq({tag, "_valid"}, 32'(ifc.ifid_valid), 32'd0);
    check_eq({tag, "_instr"}, ifc.ifid_instr, 32'h0000_0013);
    check_eq({tag, "_pc"}, ifc.ifid_pc, 32'd0);
    check_eq({tag, "_pc4"}, ifc.ifid_pc_plus4, 32'd0);
    check_eq({tag, "_fault"}, 32'(ifc.fetch_fault), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] prog8 [8];
  int writes;
  int last_addr;
  int first_nr;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    prog8 = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    rst               = 1'b1;
    ifc.load_valid    = 1'b0;
    ifc.load_data     = 8'h00;
    ifc.load_done     = 1'b0;
    ifc.stall         = 1'b0;
    ifc.branch_taken  = 1'b0;
    ifc.branch_target = 32'h0;
    #2;
    check_reset_values("rst0");
    check_eq("rst0_we", 32'(ifc.imem_we), 32'd0);
    tick();
    rst = 1'b0;

    // Full-memory load: 100 offered bytes, data = index.
    writes = 0; last_addr = -1; first_nr = -1;
    for (int c = 0; c < 100; c++) begin
      tick();
      ifc.load_valid = 1'b1;
      ifc.load_data  = c[7:0];
      #1;
      if (ifc.imem_we) begin
        writes++;
        last_addr = int'(ifc.imem_addr);
      end
      if (!ifc.load_ready && first_nr < 0) first_nr = c;
    end
    ifc.load_valid = 1'b0;
    check_eq("full_writes", 32'(writes), 32'd91);
    check_eq("full_last_addr", 32'(last_addr), 32'd90);
    check_eq("full_ready_fall", 32'(first_nr), 32'd91);
    check_eq("full_state_run", 32'(ifc.state_o), 32'd1);

    // Reset in the middle of RUN.
    rst = 1'b1;
    #1;
    check_reset_values("rst_run");
    tick();
    rst = 1'b0;

    // Eight-byte program load followed by load_done.
    for (int i = 0; i < 8; i++) begin
      tick();
      ifc.load_valid = 1'b1;
      ifc.load_data  = prog8[i];
      #1;
      check_eq("ld8_we", 32'(ifc.imem_we), 32'd1);
      check_eq("ld8_addr", ifc.imem_addr, 32'(i));
    end
    tick();
    ifc.load_valid = 1'b0;
    ifc.load_done  = 1'b1;
    #1;
    check_eq("ld8_we_off", 32'(ifc.imem_we), 32'd0);
    check_eq("ld8_still_load", 32'(ifc.state_o), 32'd0);
    tick();
    ifc.load_done = 1'b0;
    check_eq("run_state", 32'(ifc.state_o), 32'd1);
    check_eq("run_addr0", ifc.imem_addr, 32'd0);
    check_eq("run_valid0", 32'(ifc.ifid_valid), 32'd0);
    check_eq("run_ready0", 32'(ifc.load_ready), 32'd0);
    tick();
    check_eq("f0_instr", ifc.ifid_instr, 32'h1300_5000);
    check_eq("f0_pc", ifc.ifid_pc, 32'd0);
    check_eq("f0_pc4", ifc.ifid_pc_plus4, 32'd4);
    check_eq("f0_valid", 32'(ifc.ifid_valid), 32'd1);
    tick();
    check_eq("f1_instr", ifc.ifid_instr, 32'h9300_A000);
    check_eq("f1_pc", ifc.ifid_pc, 32'd4);
    check_eq("f1_addr", ifc.imem_addr, 32'd8);

    // Stall for three edges at pc 8.
    ifc.stall = 1'b1;
    tick(); tick(); tick();
    check_eq("stall_pc", ifc.ifid_pc, 32'd4);
    check_eq("stall_instr", ifc.ifid_instr, 32'h9300_A000);
    check_eq("stall_addr", ifc.imem_addr, 32'd8);
    check_eq("stall_valid", 32'(ifc.ifid_valid), 32'd1);
    ifc.stall = 1'b0;
    tick();
    check_eq("post_stall_instr", ifc.ifid_instr, 32'h0809_0A0B);
    check_eq("post_stall_pc", ifc.ifid_pc, 32'd8);
    tick();
    check_eq("post_stall2_instr", ifc.ifid_instr, 32'h0C0D_0E0F);
    check_eq("post_stall2_pc", ifc.ifid_pc, 32'd12);

    // Branch to 0x20 together with stall.
    ifc.branch_taken  = 1'b1;
    ifc.branch_target = 32'h20;
    ifc.stall         = 1'b1;
    tick();
    ifc.branch_taken = 1'b0;
    ifc.stall        = 1'b0;
    check_eq("br_valid", 32'(ifc.ifid_valid), 32'd0);
    check_eq("br_nop", ifc.ifid_instr, 32'h0000_0013);
    check_eq("br_addr", ifc.imem_addr, 32'h20);
    tick();
    check_eq("br_tgt_instr", ifc.ifid_instr, 32'h2021_2223);
    check_eq("br_tgt_pc", ifc.ifid_pc, 32'h20);
    check_eq("br_tgt_pc4", ifc.ifid_pc_plus4, 32'h24);
    check_eq("br_tgt_valid", 32'(ifc.ifid_valid), 32'd1);

    // Misaligned redirect faults one edge after it becomes pc.
    ifc.branch_taken  = 1'b1;
    ifc.branch_target = 32'h22;
    tick();
    ifc.branch_taken = 1'b0;
    check_eq("mis_state_run", 32'(ifc.state_o), 32'd1);
    check_eq("mis_fault0", 32'(ifc.fetch_fault), 32'd0);
    tick();
    check_eq("mis_halt", 32'(ifc.state_o), 32'd2);
    check_eq("mis_fault", 32'(ifc.fetch_fault), 32'd1);
    check_eq("mis_valid", 32'(ifc.ifid_valid), 32'd0);
    tick(); tick(); tick();
    check_eq("halt_stays", 32'(ifc.state_o), 32'd2);
    check_eq("halt_pc_frozen", ifc.imem_addr, 32'h22);
    check_eq("halt_fault", 32'(ifc.fetch_fault), 32'd1);

    // Reset out of HALT, skip reload, memory retained.
    rst = 1'b1;
    #1;
    check_reset_values("rst_halt");
    tick();
    rst = 1'b0;
    ifc.load_done = 1'b1;
    tick();
    ifc.load_done = 1'b0;
    check_eq("skip_state", 32'(ifc.state_o), 32'd1);
    tick();
    check_eq("retained_instr", ifc.ifid_instr, 32'h1300_5000);

    // Run off the end: last legal word at 84, 88 is illegal.
    ifc.branch_taken  = 1'b1;
    ifc.branch_target = 32'd84;
    tick();
    ifc.branch_taken = 1'b0;
    tick();
    check_eq("end_instr", ifc.ifid_instr, 32'h5455_5657);
    check_eq("end_pc", ifc.ifid_pc, 32'd84);
    check_eq("end_valid", 32'(ifc.ifid_valid), 32'd1);
    tick();
    check_eq("end_halt", 32'(ifc.state_o), 32'd2);
    check_eq("end_fault", 32'(ifc.fetch_fault), 32'd1);
    check_eq("end_valid0", 32'(ifc.ifid_valid), 32'd0);
    check_eq("end_pc_hold", ifc.ifid_pc, 32'd84);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
